// File: rtl/igen_pipe.sv
// igen_pipe: registered immediate generator with a small output FIFO.
// Each accepted instruction is decoded on the way in: format class, extended
// immediate, PC-relative target and illegal flag. The decoded record is
// queued, and the head record is presented downstream with valid/ready flow
// control on both sides.
module igen_pipe #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [31:0]                insn_i,
  input  logic [DWIDTH-1:0]          pc_i,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DWIDTH-1:0]          imm_o,
  output logic [2:0]                 fmt_o,
  output logic [DWIDTH-1:0]          target_o,
  output logic                       illegal_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Format codes presented on fmt_o
  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_CSR = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  // Supported major opcodes
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  // ---------------------------------------------------------------------
  // Input-side decode
  // ---------------------------------------------------------------------
  logic [6:0]        opcode;
  logic [2:0]        dec_fmt;
  logic [31:0]       dec_imm32;   // immediate in 32-bit form, sign at bit 31
  logic              dec_pc_rel;  // target = pc + imm for this instruction
  logic              dec_illegal;
  logic [DWIDTH-1:0] dec_imm;
  logic [DWIDTH-1:0] dec_target;

  assign opcode = insn_i[6:0];

  // funct3[1:0] never affects the immediate or format
  logic unused_funct3_lo;
  assign unused_funct3_lo = ^insn_i[13:12];

  // Classify the opcode and assemble the 32-bit immediate
  always_comb begin
    dec_fmt     = FMT_R;
    dec_imm32   = 32'd0;
    dec_pc_rel  = 1'b0;
    dec_illegal = 1'b0;
    if (insn_i[1:0] != 2'b11) begin
      dec_fmt     = FMT_ILL;
      dec_illegal = 1'b1;
    end else begin
      case (opcode)
        OP_LOAD, OP_OP_IMM, OP_JALR, OP_MISC_MEM: begin
          dec_fmt   = FMT_I;
          dec_imm32 = {{20{insn_i[31]}}, insn_i[31:20]};
        end
        OP_STORE: begin
          dec_fmt   = FMT_S;
          dec_imm32 = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
        end
        OP_BRANCH: begin
          dec_fmt    = FMT_B;
          dec_imm32  = {{19{insn_i[31]}}, insn_i[31], insn_i[7],
                        insn_i[30:25], insn_i[11:8], 1'b0};
          dec_pc_rel = 1'b1;
        end
        OP_LUI: begin
          dec_fmt   = FMT_U;
          dec_imm32 = {insn_i[31:12], 12'd0};
        end
        OP_AUIPC: begin
          dec_fmt    = FMT_U;
          dec_imm32  = {insn_i[31:12], 12'd0};
          dec_pc_rel = 1'b1;
        end
        OP_JAL: begin
          dec_fmt    = FMT_J;
          dec_imm32  = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12],
                        insn_i[20], insn_i[30:21], 1'b0};
          dec_pc_rel = 1'b1;
        end
        OP_SYSTEM: begin
          if (insn_i[14]) begin
            // CSR immediate forms carry a 5-bit unsigned zimm in rs1
            dec_fmt   = FMT_CSR;
            dec_imm32 = {27'd0, insn_i[19:15]};
          end else begin
            dec_fmt   = FMT_I;
            dec_imm32 = {{20{insn_i[31]}}, insn_i[31:20]};
          end
        end
        OP_OP: begin
          dec_fmt = FMT_R;
        end
        default: begin
          dec_fmt     = FMT_ILL;
          dec_illegal = 1'b1;
        end
      endcase
    end
  end

  // Widen the immediate to the datapath; bit 31 is the sign in every form
  // (the CSR zimm has bit 31 clear, so it comes out zero-extended)
  generate
    if (DWIDTH == 32) begin : g_imm32
      assign dec_imm = dec_imm32;
    end else begin : g_immw
      assign dec_imm = {{(DWIDTH-32){dec_imm32[31]}}, dec_imm32};
    end
  endgenerate

  // PC-relative target, wrapping modulo 2^DWIDTH
  assign dec_target = dec_pc_rel ? (pc_i + dec_imm) : '0;

  // ---------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------
  logic [PW-1:0] wptr_reg, wptr_next;
  logic [PW-1:0] rptr_reg, rptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          ready_en_reg;   // low in reset and the cycle after release
  logic          push;
  logic          pop;

  assign in_ready_o  = ready_en_reg && (count_reg < FULL_COUNT);
  assign out_valid_o = (count_reg != '0);
  assign count_o     = count_reg;

  // Flush wins over both transfers
  assign push = in_valid_i && in_ready_o && !flush_i;
  assign pop  = out_valid_o && out_ready_i && !flush_i;

  // Next pointer and occupancy values
  always_comb begin
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    count_next = count_reg;
    if (flush_i) begin
      wptr_next  = '0;
      rptr_next  = '0;
      count_next = '0;
    end else begin
      if (push) wptr_next = wptr_reg + PW'(1);
      if (pop)  rptr_next = rptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Control state with asynchronous reset; reset drops all entries
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      count_reg    <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      wptr_reg     <= wptr_next;
      rptr_reg     <= rptr_next;
      count_reg    <= count_next;
      ready_en_reg <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Payload storage (no reset; validity is tracked by count_reg)
  // ---------------------------------------------------------------------
  logic [DWIDTH-1:0] imm_mem    [DEPTH];
  logic [DWIDTH-1:0] target_mem [DEPTH];
  logic [2:0]        fmt_mem    [DEPTH];
  logic              ill_mem    [DEPTH];

  // Write the decoded record into the tail slot on push
  always_ff @(posedge clk_i) begin
    if (push) begin
      imm_mem[wptr_reg]    <= dec_imm;
      target_mem[wptr_reg] <= dec_target;
      fmt_mem[wptr_reg]    <= dec_fmt;
      ill_mem[wptr_reg]    <= dec_illegal;
    end
  end

  // Head record, forced to zero while the FIFO is empty
  always_comb begin
    imm_o     = '0;
    target_o  = '0;
    fmt_o     = 3'd0;
    illegal_o = 1'b0;
    if (out_valid_o) begin
      imm_o     = imm_mem[rptr_reg];
      target_o  = target_mem[rptr_reg];
      fmt_o     = fmt_mem[rptr_reg];
      illegal_o = ill_mem[rptr_reg];
    end
  end

endmodule

// File: tb/tb_igen_pipe.sv
// Scoreboard bench for igen_pipe. Two instances (DWIDTH 32 and 64, DEPTH 2)
// share the same stimulus. The driver pushes a model-computed record for each
// accepted instruction; the monitor compares the head of each DUT against the
// queue every cycle and pops on a downstream transfer.
module tb_igen_pipe;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] tgt;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] insn = 32'd0;
  logic [63:0] pc64 = 64'd0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32, tgt32;
  logic [2:0]  fmt32;
  logic [1:0]  cnt32;

  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64, tgt64;
  logic [2:0]  fmt64;
  logic [1:0]  cnt64;

  exp_t exp_q[$];
  logic armed = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  igen_pipe #(.DWIDTH(32), .DEPTH(DEPTH)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready32),
    .insn_i(insn), .pc_i(pc64[31:0]), .flush_i(flush), .out_valid_o(out_valid32),
    .out_ready_i(out_ready), .imm_o(imm32), .fmt_o(fmt32), .target_o(tgt32),
    .illegal_o(ill32), .count_o(cnt32)
  );

  igen_pipe #(.DWIDTH(64), .DEPTH(DEPTH)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready64),
    .insn_i(insn), .pc_i(pc64), .flush_i(flush), .out_valid_o(out_valid64),
    .out_ready_i(out_ready), .imm_o(imm64), .fmt_o(fmt64), .target_o(tgt64),
    .illegal_o(ill64), .count_o(cnt64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference decode written from the immediate bit-placement rules with
  // plain integer arithmetic, always at 64 bits; the 32-bit DUT is compared
  // against the low half.
  function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc);
    exp_t   e;
    int     s;
    longint v;
    bit     rel;
    e   = '0;
    s   = $signed(w);
    v   = 0;
    rel = 1'b0;
    if (w[1:0] != 2'b11) begin
      e.fmt = 3'd7;
      e.ill = 1'b1;
      return e;
    end
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F: begin e.fmt = 3'd1; v = longint'(s >>> 20); end
      7'h23: begin
        e.fmt = 3'd2;
        v = longint'(s >>> 25) * 32 + longint'(w[11:7]);
      end
      7'h63: begin
        e.fmt = 3'd3; rel = 1'b1;
        v = longint'(s >>> 31) * 4096 + longint'(w[7]) * 2048
          + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
      end
      7'h37: begin e.fmt = 3'd4; v = longint'(s >>> 12) * 4096; end
      7'h17: begin e.fmt = 3'd4; rel = 1'b1; v = longint'(s >>> 12) * 4096; end
      7'h6F: begin
        e.fmt = 3'd5; rel = 1'b1;
        v = longint'(s >>> 31) * 1048576 + longint'(w[19:12]) * 4096
          + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
      end
      7'h73: begin
        if (w[14]) begin e.fmt = 3'd6; v = longint'(w[19:15]); end
        else       begin e.fmt = 3'd1; v = longint'(s >>> 20); end
      end
      7'h33: e.fmt = 3'd0;
      default: begin e.fmt = 3'd7; e.ill = 1'b1; end
    endcase
    e.imm = 64'(v);
    e.tgt = rel ? (pc + 64'(v)) : 64'd0;
    return e;
  endfunction

  // Monitor: compare both DUTs with the scoreboard every cycle, pop on transfer
  always @(negedge clk) begin
    exp_t h;
    logic hv;
    logic erdy;
    if (rst_n) begin
      hv   = (exp_q.size() != 0);
      erdy = armed && (exp_q.size() < DEPTH);
      h    = hv ? exp_q[0] : '0;
      chk("count32", 64'(cnt32), 64'(exp_q.size()));
      chk("count64", 64'(cnt64), 64'(exp_q.size()));
      chk("in_ready32", 64'(in_ready32), 64'(erdy));
      chk("in_ready64", 64'(in_ready64), 64'(erdy));
      chk("out_valid32", 64'(out_valid32), 64'(hv));
      chk("out_valid64", 64'(out_valid64), 64'(hv));
      chk("fmt32", 64'(fmt32), 64'(h.fmt));
      chk("fmt64", 64'(fmt64), 64'(h.fmt));
      chk("imm32", 64'(imm32), 64'(h.imm[31:0]));
      chk("imm64", imm64, h.imm);
      chk("target32", 64'(tgt32), 64'(h.tgt[31:0]));
      chk("target64", tgt64, h.tgt);
      chk("illegal32", 64'(ill32), 64'(h.ill));
      chk("illegal64", 64'(ill64), 64'(h.ill));
      if (hv && out_ready) begin
        $display("pop  fmt=%0d imm=%h target=%h illegal=%0d", h.fmt, h.imm, h.tgt, h.ill);
        exp_q.delete(0);
      end
    end
  end

  // One bus cycle: drive after the edge, record the accepted push before the next edge
  task automatic cycle(input logic v, input logic [31:0] w, input logic [63:0] pc,
                       input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    insn      = w;
    pc64      = pc;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (fl) begin
        exp_q.delete();
      end else if (v && in_ready32) begin
        exp_q.push_back(model(w, pc));
        $display("push insn=%h pc=%h", w, pc);
      end
    end
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 32'd0, 64'd0, rdy, 1'b0);
  endtask

  // Head check against spec constants, then pop it at the end of this cycle
  task automatic expect_pop(input string name, input logic [2:0] f, input logic [63:0] imm,
                            input logic [63:0] tgt, input logic il);
    idle(1'b1);
    chk({name, "_valid"}, 64'(out_valid32 & out_valid64), 64'd1);
    chk({name, "_fmt32"}, 64'(fmt32), 64'(f));
    chk({name, "_fmt64"}, 64'(fmt64), 64'(f));
    chk({name, "_imm32"}, 64'(imm32), 64'(imm[31:0]));
    chk({name, "_imm64"}, imm64, imm);
    chk({name, "_tgt32"}, 64'(tgt32), 64'(tgt[31:0]));
    chk({name, "_tgt64"}, tgt64, tgt);
    chk({name, "_ill"}, 64'({ill32, ill64}), 64'({il, il}));
  endtask

  // Asynchronous reset asserted mid-cycle; its effect must be immediate
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    armed     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_count", 64'({cnt32, cnt64}), 64'd0);
    chk("rst_in_ready", 64'({in_ready32, in_ready64}), 64'd0);
    chk("rst_out_valid", 64'({out_valid32, out_valid64}), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    armed = 1'b1;
  endtask

  logic [6:0] op_tab [12] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h23, 7'h63,
                              7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h7F};

  initial begin
    logic [31:0] r;
    int          k;
    do_reset();

    // Single branch push, then drain
    cycle(1'b1, 32'hFE208EE3, 64'h1000, 1'b0, 1'b0);
    chk("count_before_visible", 64'(cnt32), 64'd0);
    expect_pop("beq", 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0FFC, 1'b0);
    idle(1'b0);
    chk("empty_after_pop", 64'({out_valid32, out_valid64, cnt32}), 64'd0);

    // JAL and CSR immediate
    cycle(1'b1, 32'h001000EF, 64'h2000, 1'b0, 1'b0);
    cycle(1'b1, 32'h3002D0F3, 64'h2004, 1'b0, 1'b0);
    expect_pop("jal", 3'd5, 64'h800, 64'h2800, 1'b0);
    expect_pop("csrrwi", 3'd6, 64'h5, 64'h0, 1'b0);

    // Illegal encodings next to a valid addi
    cycle(1'b1, 32'h0000007F, 64'h3000, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000012, 64'h3004, 1'b0, 1'b0);
    expect_pop("ill_op", 3'd7, 64'h0, 64'h0, 1'b1);
    cycle(1'b1, 32'hFFB10093, 64'h3008, 1'b1, 1'b0);
    chk("ill_bits_head", 64'({fmt32, ill32}), 64'({3'd7, 1'b1}));
    expect_pop("addi", 3'd1, 64'hFFFF_FFFF_FFFF_FFFB, 64'h0, 1'b0);

    // AUIPC wraps; LUI sign-extends at 64 bits
    cycle(1'b1, 32'h00001097, 64'hFFFF_FFFF_FFFF_F000, 1'b0, 1'b0);
    cycle(1'b1, 32'h800000B7, 64'h4000, 1'b0, 1'b0);
    expect_pop("auipc_wrap", 3'd4, 64'h1000, 64'h0, 1'b0);
    expect_pop("lui", 3'd4, 64'hFFFF_FFFF_8000_0000, 64'h0, 1'b0);

    // Backpressure: third push held while full, ready independent of out_ready
    cycle(1'b1, 32'h00410113, 64'h5000, 1'b0, 1'b0);
    cycle(1'b1, 32'h00812023, 64'h5004, 1'b0, 1'b0);
    cycle(1'b1, 32'hFE0008E3, 64'h5008, 1'b0, 1'b0);
    chk("full_count", 64'(cnt32), 64'd2);
    chk("full_in_ready", 64'({in_ready32, in_ready64}), 64'd0);
    cycle(1'b1, 32'hFE0008E3, 64'h5008, 1'b1, 1'b0);
    chk("full_ready_ignores_out_ready", 64'(in_ready32), 64'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'h00100093 + (i << 20), 64'h6000 + 64'(i * 4), 1'b1, 1'b0);
      if (i > 0) chk("pushpop_count", 64'({cnt32, cnt64}), 64'({2'd1, 2'd1}));
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // Flush with two entries and a concurrent input
    cycle(1'b1, 32'h00500093, 64'h7000, 1'b0, 1'b0);
    cycle(1'b1, 32'h00600093, 64'h7004, 1'b0, 1'b0);
    cycle(1'b1, 32'h00700093, 64'h7008, 1'b1, 1'b1);
    chk("pre_flush_count", 64'(cnt32), 64'd2);
    idle(1'b0);
    chk("flush_count", 64'({cnt32, cnt64}), 64'd0);
    chk("flush_valid", 64'({out_valid32, out_valid64}), 64'd0);
    chk("flush_outputs", imm64 | tgt64 | 64'(imm32) | 64'(tgt32) | 64'({fmt32, fmt64, ill32, ill64}), 64'd0);
    chk("flush_in_ready", 64'({in_ready32, in_ready64}), 64'd3);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      k = $urandom_range(0, 12);
      cycle($urandom_range(0, 3) != 0,
            (k == 12) ? r : {r[31:7], op_tab[k]},
            {32'($urandom()), 32'($urandom())},
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0);
    end

    // Asynchronous reset mid-stream
    idle(1'b1);
    idle(1'b1);
    cycle(1'b1, 32'h00812023, 64'h8000, 1'b0, 1'b0);
    cycle(1'b1, 32'h001000EF, 64'h8004, 1'b0, 1'b0);
    do_reset();
    for (int n = 0; n < 20; n++) begin
      r = $urandom();
      k = $urandom_range(0, 11);
      cycle(1'b1, {r[31:7], op_tab[k]}, {32'd0, r}, $urandom_range(0, 1) == 1, 1'b0);
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/igen_pipe.md
Name: igen_pipe

Overview:
Registered, flow-controlled successor to the combinational immediate generator. Decodes the opcode directly from the instruction word and classifies the instruction format. Produces a sign/zero-extended immediate of parametrised width, precomputes PC-relative targets, and flags illegal opcodes. Results are buffered in a DEPTH-entry FIFO with valid/ready handshakes on both sides, between fetch and decode/execute.

Parameters:
DWIDTH, 32, datapath width for imm/pc/target; legal values 32 or 64.
DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  reset, asynchronous, active-low.
in_valid_i  input  1  upstream has an instruction.
in_ready_o  output  1  block can accept; equals (count_o < DEPTH), not dependent on out_ready_i.
insn_i  input  32  instruction word; opcode = insn_i[6:0].
pc_i  input  DWIDTH  PC of insn_i.
flush_i  input  1  synchronous flush of all buffered entries.
out_valid_o  output  1  head entry valid; equals (count_o != 0).
out_ready_i  input  1  downstream accepts head.
imm_o  output  DWIDTH  immediate of head entry.
fmt_o  output  3  format: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR-zimm, 7 illegal.
target_o  output  DWIDTH  pc+imm for B, J, AUIPC; else 0.
illegal_o  output  1  head entry has unsupported opcode or insn[1:0] != 2'b11.
count_o  output  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (rst_ni low, async): count_o=0, read/write pointers=0, out_valid_o=0, in_ready_o=0. in_ready_o=1 from first clock after deassertion. Reset mid-transfer drops all entries.
- imm_o, fmt_o, target_o, illegal_o are forced to 0 whenever out_valid_o=0. Payload storage needs no reset.
- Push when in_valid_i && in_ready_o; pop when out_valid_o && out_ready_i. Push and pop may occur in the same cycle: count unchanged, pointers both advance, wrapping mod DEPTH.
- No push when full (ready low). No pop when empty.
- Latency: an entry pushed in cycle N is visible at out_valid_o in cycle N+1 (no bypass).
- Head outputs are stable while out_valid_o && !out_ready_i.
- flush_i has priority over push and pop: next cycle count=0, pointers=0. An input presented in the flush cycle is discarded. in_ready_o stays per count rule.
- Decode, combinational on the input side and stored with the entry. Immediates are sign-extended from bit 31 to DWIDTH unless stated:
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111, MISC-MEM 0001111: I, insn[31:20].
  - STORE 0100011: S, {insn[31:25],insn[11:7]}.
  - BRANCH 1100011: B, {insn[31],insn[7],insn[30:25],insn[11:8],0}.
  - LUI 0110111, AUIPC 0010111: U, {insn[31:12],12'b0}, sign-extended for DWIDTH=64.
  - JAL 1101111: J, {insn[31],insn[19:12],insn[20],insn[30:21],0}.
  - SYSTEM 1110011: funct3[2]=1 gives CSR, imm = zero-extended insn[19:15]. Otherwise I.
  - OP 0110011: fmt 0, imm 0.
  - Any other opcode, or insn[1:0] != 11: fmt 7, illegal=1, imm 0, target 0. The entry is still queued.
- target = pc_i + imm, modulo 2^DWIDTH (wraps silently), for B, J and AUIPC only.

Test Plan:
- Reset then single push, DWIDTH=32: insn FE208EE3, pc 0x1000 -> next cycle out_valid=1, fmt 3, imm FFFFFFFC, target 00000FFC, count 1. Pop empties.
- JAL 001000EF, pc 0x2000 -> fmt 5, imm 00000800, target 00002800. csrrwi 3002D0F3 -> fmt 6, imm 00000005, target 0.
- Backpressure, DEPTH=2, out_ready=0, three pushes -> in_ready low after 2nd accept, count 2, third held. Raise out_ready -> entries emerge in order, each stable until popped. Simultaneous push/pop keeps count 1 across 4 cycles with pointer wrap.
- Illegal 0000007F and 00000012 -> fmt 7, illegal 1, imm 0. Adjacent valid addi FFB10093 -> imm FFFFFFFB unaffected.
- AUIPC 00001097, pc FFFFF000 -> imm 00001000, target 00000000 (wrap). DWIDTH=64: addi FFB10093 -> imm FFFFFFFFFFFFFFFB. LUI 800000B7 -> FFFFFFFF80000000.
- flush_i with count 2 and concurrent in_valid -> next cycle count 0, out_valid 0, outputs 0. Async rst_ni low mid-stream -> immediate count 0, in_ready 0.
